// File: rtl/dense_layer.sv
// Fully-connected layer: y[i] = sat((sum_j x[j]*W[i][j] + (b[i] << FRAC)) >>> FRAC).
// One MAC per clock, plus one write cycle per neuron; operands are captured at start.
module dense_layer #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int FP_TOTAL_BITS = 16,
    parameter int FP_FRAC_BITS  = 8
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      start,
    input  logic [NUM_INPUTS-1:0][FP_TOTAL_BITS-1:0]                  input_vector,
    input  logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0][FP_TOTAL_BITS-1:0] weight_matrix,
    input  logic [NUM_OUTPUTS-1:0][FP_TOTAL_BITS-1:0]                 bias_vector,
    output logic [NUM_OUTPUTS-1:0][FP_TOTAL_BITS-1:0]                 layer_out,
    output logic                                                      busy,
    output logic                                                      done
);
    localparam int W     = FP_TOTAL_BITS;
    localparam int PW    = 2 * W;
    localparam int ACC_W = PW + $clog2(NUM_INPUTS) + 1;
    localparam int IW    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int JW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(NUM_OUTPUTS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NUM_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                                             r_state;
    logic [NUM_INPUTS-1:0][W-1:0]                       r_x;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0][W-1:0]      r_w;
    logic [NUM_OUTPUTS-1:0][W-1:0]                      r_b;
    logic [NUM_OUTPUTS-1:0][W-1:0]                      r_out;
    logic signed [ACC_W-1:0]                            r_acc;
    logic [IW-1:0]                                      r_i;
    logic [JW-1:0]                                      r_j;
    logic                                               r_busy;
    logic                                               r_done;

    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic [W-1:0]            w_sat;

    always_comb begin
        w_prod     = $signed(r_x[r_j]) * $signed(r_w[r_i][r_j]);
        w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
        w_bias_ext = {{(ACC_W-W){r_b[r_i][W-1]}}, r_b[r_i]};
        w_sum      = r_acc + (w_bias_ext <<< FP_FRAC_BITS);
        // Arithmetic shift floors toward -inf; no rounding term is added.
        w_shift    = w_sum >>> FP_FRAC_BITS;
        if (w_shift > SAT_MAX)
            w_sat = SAT_MAX[W-1:0];
        else if (w_shift < SAT_MIN)
            w_sat = SAT_MIN[W-1:0];
        else
            w_sat = w_shift[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_w     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x     <= input_vector;
                        r_w     <= weight_matrix;
                        r_b     <= bias_vector;
                        r_out   <= '0;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_j   <= r_j + JW'(1);
                    if (r_j == J_LAST)
                        r_state <= WRITE;
                end
                WRITE: begin
                    r_out[r_i] <= w_sat;
                    r_acc      <= '0;
                    r_j        <= '0;
                    if (r_i != I_LAST) begin
                        r_i     <= r_i + IW'(1);
                        r_state <= MAC;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign layer_out = r_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer at 4x4 Q7.8, with a behavioural ReLU stage hung off done.
module tb_dense_layer;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [NI-1:0][FW-1:0]         x;
    logic [NO-1:0][NI-1:0][FW-1:0] wm;
    logic [NO-1:0][FW-1:0]         b;
    logic [NO-1:0][FW-1:0]         lo;
    logic busy, done;
    int   relu_out [NO];

    int n_cmp = 0;
    int n_err = 0;

    dense_layer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .FP_TOTAL_BITS(FW), .FP_FRAC_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .input_vector(x), .weight_matrix(wm),
        .bias_vector(b), .layer_out(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream ReLU stage model: latches max(y,0) when the layer signals done.
    always @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NO; k++) relu_out[k] <= 0;
        end else if (done) begin
            for (int k = 0; k < NO; k++)
                relu_out[k] <= ($signed(lo[k]) > 0) ? int'($signed(lo[k])) : 0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int y(input int k);
        return int'($signed(lo[k]));
    endfunction

    // x all xv; row i of W all w[i]; bias b[i].
    task automatic load(input int xv, input int w0, input int w1, input int w2, input int w3,
                        input int b0, input int b1, input int b2, input int b3);
        int wr [NO];
        int br [NO];
        wr = '{w0, w1, w2, w3};
        br = '{b0, b1, b2, b3};
        for (int j = 0; j < NI; j++) x[j] = FW'(xv);
        for (int i = 0; i < NO; i++) begin
            b[i] = FW'(br[i]);
            for (int j = 0; j < NI; j++) wm[i][j] = FW'(wr[i]);
        end
    endtask

    // mode 0: plain; 1: inputs change at edge 3 and start re-pulsed at edge 5; 2: reset at edge 10.
    task automatic run_eval(input string tag, input int mode,
                            input int e0, input int e1, input int e2, input int e3);
        int ex [NO];
        ex = '{e0, e1, e2, e3};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < NO; k++) chk({tag, " clr_at_start"}, y(k), 0);
        chk({tag, " busy_e0"}, int'(busy), 1);
        for (int e = 1; e <= 21; e++) begin
            if (mode == 1 && e == 3) load(-100, 5, 5, 5, 5, 7, 7, 7, 7);
            if (mode == 1 && e == 5) start = 1'b1;
            if (mode == 2 && e == 10) reset = 1'b0;
            step();
            start = 1'b0;
            reset = 1'b1;
            chk($sformatf("%s done_e%0d", tag, e), int'(done), (mode != 2 && e == 20) ? 1 : 0);
            chk($sformatf("%s busy_e%0d", tag, e), int'(busy),
                ((mode == 2) ? (e < 10) : (e < 20)) ? 1 : 0);
            if (e == 5) begin
                chk({tag, " y0_at_e5"}, y(0), ex[0]);
                chk({tag, " y1_hold_e5"}, y(1), 0);
            end
            if (mode == 2 && e == 10)
                for (int k = 0; k < NO; k++) chk($sformatf("%s rst_y%0d", tag, k), y(k), 0);
        end
        if (mode != 2)
            for (int k = 0; k < NO; k++) chk($sformatf("%s y%0d", tag, k), y(k), ex[k]);
    endtask

    initial begin
        load(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        for (int k = 0; k < NO; k++) chk($sformatf("reset y%0d", k), y(k), 0);
        reset = 1'b1;
        step();

        load(256, 256, -256, 0, 0, 0, 128, -512, 32767);
        run_eval("basic", 0, 1024, -896, -512, 32767);
        chk("relu0", relu_out[0], 1024);
        chk("relu1", relu_out[1], 0);
        chk("relu2", relu_out[2], 0);
        chk("relu3", relu_out[3], 32767);

        load(32767, 32767, 32767, 32767, 32767, 0, 0, 0, 0);
        run_eval("sat_pos", 0, 32767, 32767, 32767, 32767);
        load(32767, -32768, -32768, -32768, -32768, 0, 0, 0, 0);
        run_eval("sat_neg", 0, -32768, -32768, -32768, -32768);

        load(1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_eval("trunc_pos", 0, 0, 0, 0, 0);
        load(-1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_eval("trunc_neg", 0, -1, 0, 0, 0);

        load(256, 256, -256, 0, 0, 0, 128, -512, 32767);
        run_eval("busy_start", 1, 1024, -896, -512, 32767);
        step();
        chk("no_requeue busy", int'(busy), 0);

        load(256, 256, -256, 0, 0, 0, 128, -512, 32767);
        run_eval("rst_mid", 2, 1024, -896, -512, 32767);
        run_eval("after_rst", 0, 1024, -896, -512, 32767);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
